// File: rtl/stack_seq.sv
// Push/pop sequencer owning the downward-growing stack pointer; one request in flight at a time.
// Latency: 2 cycles request-to-response (+1 per mem_ready-low cycle), 1 cycle for over/underflow errors; no request accepted until the response is consumed.
module stack_seq #(
  parameter int unsigned     SIZE        = 32,
  parameter logic [SIZE-1:0] STACK_TOP   = 'h1000,
  parameter logic [SIZE-1:0] STACK_LIMIT = 'h0F00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_pop,
  input  logic [SIZE-1:0] req_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [SIZE-1:0] resp_data,
  output logic            resp_err,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [SIZE-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [SIZE-1:0] sp,
  output logic            empty,
  output logic            full
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   req_bad;

  assign empty   = (sp == STACK_TOP);
  assign full    = (sp == STACK_LIMIT);
  assign accept  = req_valid && req_ready;
  // Push onto a full stack or pop from an empty one never touches memory.
  assign req_bad = req_pop ? empty : full;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)      state_nxt = RESP;
          else if (req_pop) state_nxt = READ;
          else              state_nxt = WRITE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_ready) state_nxt = RESP;
      end
      READ: begin
        mem_re = 1'b1;
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sp        <= STACK_TOP;
      resp_data <= '0;
      resp_err  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              resp_err  <= 1'b1;
              resp_data <= '0;
            end else if (req_pop) begin
              mem_addr <= sp;
            end else begin
              mem_addr  <= sp - SIZE'(1);
              mem_wdata <= req_data;
            end
          end
        end
        // SP moves only when the memory access actually completes.
        WRITE: begin
          if (mem_ready) begin
            sp        <= sp - SIZE'(1);
            resp_data <= '0;
            resp_err  <= 1'b0;
          end
        end
        READ: begin
          if (mem_ready) begin
            sp        <= sp + SIZE'(1);
            resp_data <= mem_rdata;
            resp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Randomized scoreboard bench for stack_seq against a queue-based stack model.
module tb_stack_seq;
  localparam logic [31:0] TOP   = 32'd16;
  localparam logic [31:0] LIMIT = 32'd12;
  localparam int          CAP   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_pop = 1'b0;
  logic [31:0] req_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] sp;
  logic        empty;
  logic        full;

  stack_seq #(.SIZE(32), .STACK_TOP(TOP), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pop(req_pop), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sp(sp), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pop;
    bit          acc;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [31:0] sp_b;
    logic [31:0] sp_a;
    int          lat;
    int          strobes;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] stk[$];
  logic [31:0] mem [logic [31:0]];

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;
  int stall_left = 0;
  int rr_hold = 0;
  bit rr_rand = 1'b0;
  bit busy = 1'b0;
  bit lat_done = 1'b0;
  int lat = 0;
  int strobes = 0;
  exp_t m_e;
  bit rp;
  int n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Issue one request; the expected response is computed from the stack model at accept.
  task automatic do_op(input bit pop, input logic [31:0] d, input int stall, input bit timed);
    exp_t e;
    int   w;
    @(negedge clk);
    req_valid = 1'b1;
    req_pop   = pop;
    req_data  = d;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, w);
      req_valid = 1'b0;
      return;
    end
    e.pop   = pop;
    e.acc   = 1'b0;
    e.err   = 1'b0;
    e.addr  = '0;
    e.wdata = d;
    e.data  = '0;
    e.sp_b  = TOP - 32'(stk.size());
    if (!pop) begin
      if (stk.size() == CAP) e.err = 1'b1;
      else begin
        e.acc  = 1'b1;
        e.addr = e.sp_b - 32'd1;
        stk.push_back(d);
      end
    end else begin
      if (stk.size() == 0) e.err = 1'b1;
      else begin
        e.acc  = 1'b1;
        e.addr = e.sp_b;
        e.data = stk.pop_back();
      end
    end
    e.sp_a    = TOP - 32'(stk.size());
    e.lat     = !timed ? -1 : (e.err ? 1 : 2 + stall);
    e.strobes = !timed ? -1 : (e.err ? 0 : 1 + stall);
    stall_left = e.err ? 0 : stall;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_pop   = 1'($urandom_range(0, 1));
    req_data  = $urandom;
  endtask

  // Memory and response-side environment.
  initial forever begin
    @(negedge clk);
    if (mem_we || mem_re) begin
      if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
    if (mem_re) mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
    else        mem_rdata = $urandom;
    if (rst && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
    if (rr_hold > 0 && resp_valid) begin
      resp_ready = 1'b0;
      rr_hold--;
    end else begin
      resp_ready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: compares against the head of the scoreboard whenever the DUT is busy or responding.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      busy     = 1'b0;
      lat_done = 1'b0;
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      if (busy && sbq.size() > 0) begin
        m_e = sbq[0];
        lat++;
        if (mem_we || mem_re) begin
          strobes++;
          checks++;
          if (!(m_e.acc && mem_we == !m_e.pop && mem_re == m_e.pop && mem_addr == m_e.addr &&
                (!mem_we || mem_wdata == m_e.wdata) && sp == m_e.sp_b)) begin
            errors++;
            $display("FAIL access: we=%0b re=%0b addr=%0h wdata=%0h sp=%0h required acc=%0b pop=%0b addr=%0h wdata=%0h sp=%0h",
                     mem_we, mem_re, mem_addr, mem_wdata, sp, m_e.acc, m_e.pop, m_e.addr, m_e.wdata, m_e.sp_b);
          end
        end
        if (resp_valid) begin
          chk("resp_data", resp_data, m_e.data);
          chk("resp_err", {31'd0, resp_err}, {31'd0, m_e.err});
          if (!lat_done) begin
            lat_done = 1'b1;
            if (m_e.lat >= 0)     chk("latency", lat, m_e.lat);
            if (m_e.strobes >= 0) chk("strobe_cycles", strobes, m_e.strobes);
          end
          if (resp_ready) begin
            chk("sp", sp, m_e.sp_a);
            chk("empty", {31'd0, empty}, {31'd0, m_e.sp_a == TOP});
            chk("full", {31'd0, full}, {31'd0, m_e.sp_a == LIMIT});
            sbq.delete(0);
            busy     = 1'b0;
            lat_done = 1'b0;
          end
        end
      end else begin
        chk("idle_strobe", {30'd0, mem_we, mem_re}, 32'd0);
        chk("idle_resp", {31'd0, resp_valid}, 32'd0);
      end
      if (req_valid && req_ready) begin
        busy    = 1'b1;
        lat     = 0;
        strobes = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sp", sp, TOP);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;

    // Basic push/pop ordering, then underflow.
    do_op(1'b0, 32'hA, 0, 1'b1);
    do_op(1'b0, 32'hB, 0, 1'b1);
    do_op(1'b1, 32'h0, 0, 1'b1);
    do_op(1'b1, 32'h0, 0, 1'b1);
    do_op(1'b1, 32'h0, 0, 1'b1);

    // Fill to the limit, overflow, drain.
    for (int i = 1; i <= 5; i++) do_op(1'b0, 32'h100 + 32'(i), 0, 1'b1);
    for (int i = 0; i < 4; i++) do_op(1'b1, 32'h0, 0, 1'b1);

    // Memory stall, then a held response with a request queued behind it.
    do_op(1'b0, 32'hC0DE, 3, 1'b1);
    rr_hold = 5;
    do_op(1'b0, 32'hBEEF, 0, 1'b1);
    do_op(1'b0, 32'hF00D, 0, 1'b1);

    // Reset during a stalled read.
    do_op(1'b1, 32'h0, 20, 1'b0);
    @(negedge clk);
    chk("pre_reset_re", {31'd0, mem_re}, 32'd1);
    rst = 1'b0;
    sbq.delete();
    stk.delete();
    stall_left = 0;
    rr_hold = 0;
    @(negedge clk);
    chk("post_reset_re", {31'd0, mem_re}, 32'd0);
    chk("post_reset_we", {31'd0, mem_we}, 32'd0);
    chk("post_reset_sp", sp, TOP);
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    do_op(1'b1, 32'h0, 0, 1'b1);

    // Randomized traffic with random memory and response backpressure.
    ready_pct = 70;
    rr_rand   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (stk.size() == 0)        rp = ($urandom_range(0, 3) == 0);
      else if (stk.size() == CAP) rp = ($urandom_range(0, 3) != 0);
      else                        rp = 1'($urandom_range(0, 1));
      do_op(rp, $urandom, int'($urandom_range(0, 2)), 1'b0);
    end

    n = 0;
    while ((sbq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Push/pop sequencer for the CPU's downward-growing memory stack. It owns the stack pointer and accepts one push or pop request at a time over a valid/ready handshake. It drives the word-addressed memory port with pre-decrement-write (push) or read-post-increment (pop) semantics, and returns data plus an overflow/underflow error. It sits between the control unit and the memory bus arbiter, replacing ad-hoc sequencing of push/pop micro-ops.

## Interface
- SIZE, 32, data/address width in bits
- STACK_TOP, 'h1000, empty-stack SP value (word address); reset value of SP
- STACK_LIMIT, 'h0F00, lowest legal SP; must be < STACK_TOP

- clk  input  1  clock; all state changes on posedge
- rst  input  1  reset, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_pop  input  1  0 = push, 1 = pop; sampled on accept
- req_data  input  SIZE  push data; sampled on accept
- resp_valid  output  1  response present
- resp_ready  input  1  response consumed when resp_valid & resp_ready
- resp_data  output  SIZE  popped word (0 for push or error)
- resp_err  output  1  push on full, or pop on empty
- mem_addr  output  SIZE  memory word address
- mem_wdata  output  SIZE  write data
- mem_we  output  1  write strobe, held until mem_ready
- mem_re  output  1  read strobe, held until mem_ready
- mem_rdata  input  SIZE  read data, valid when mem_ready & mem_re
- mem_ready  input  1  memory completes the current access this cycle
- sp  output  SIZE  current stack pointer (registered)
- empty  output  1  sp == STACK_TOP
- full  output  1  sp == STACK_LIMIT

## Operation
- States: IDLE, WRITE, READ, RESP. req_ready = (state == IDLE); no other state accepts requests.
- IDLE, on accept:
  - Push with full, or pop with empty: set resp_err = 1 and resp_data = 0, leave sp unchanged, issue no memory access, go to RESP.
  - Push: latch mem_addr = sp - 1 and mem_wdata = req_data, go to WRITE.
  - Pop: latch mem_addr = sp, go to READ.
- WRITE: mem_we = 1. On mem_ready: sp <= sp - 1, resp_data <= 0, resp_err <= 0, go to RESP.
- READ: mem_re = 1. On mem_ready: resp_data <= mem_rdata, sp <= sp + 1, resp_err <= 0, go to RESP.
- RESP: resp_valid = 1. resp_data and resp_err are held stable until resp_ready; then go to IDLE.
- SP updates only on memory completion, never on accept. A pending access that has not completed leaves sp unchanged.
- Arithmetic is SIZE-bit modulo. Legal parameters guarantee no wrap between STACK_LIMIT and STACK_TOP.
- mem_addr and mem_wdata are registered and stable for the whole access. They are don't-care outside WRITE/READ, but implemented as holding their last value.

## Timing
- Reset (rst low at posedge): state = IDLE, sp = STACK_TOP, empty = 1, full = 0, req_ready = 1, resp_valid = 0, resp_data = 0, resp_err = 0, mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0.
- Reset mid-access abandons the access. mem_we/mem_re are low from the cycle after the reset edge, and there is no SP update.
- Push/pop latency with mem_ready tied high: accept at edge N, strobe high during cycle N+1, resp_valid high after edge N+2. Request-to-response is 2 cycles; throughput is one op per 3 cycles when resp_ready is held high.
- Each mem_ready-low cycle adds one cycle of latency.
- Error response: accept at edge N, resp_valid high after edge N+1.
- mem_we and mem_re are never high together.

## Test plan
- Reset, then push 'hA, 'hB with mem_ready = 1 → writes at STACK_TOP-1, STACK_TOP-2; sp = STACK_TOP-2; resp_err = 0; each resp_valid arrives 2 cycles after accept.
- Then pop twice → reads at STACK_TOP-2, STACK_TOP-1 return 'hB, 'hA; sp = STACK_TOP; empty = 1.
- STACK_TOP = 16, STACK_LIMIT = 12: 4 pushes succeed (full = 1, sp = 12), 5th push → resp_err = 1, no mem_we, sp = 12; pop on empty stack → resp_err = 1, resp_data = 0, no mem_re.
- Push with mem_ready low for 3 cycles → mem_we held 4 cycles with stable addr/data; sp changes only on the completion edge; req_ready stays 0 throughout.
- resp_ready low for 5 cycles → resp_valid, resp_data, resp_err held; a req_valid presented meanwhile is not accepted until the cycle after resp_ready.
- Assert rst during READ with mem_ready low → next cycle mem_re = 0, sp = STACK_TOP, state IDLE; a later pop reports underflow.
